// File: rtl/trap_sequencer_if.sv
// ============================================================================
//  Module      : trap_sequencer_if
//  Description : Request / CSR / redirect bundle between the trap sequencer
//                and its surroundings (decode, CSR file, fetch).
//                master : drives requests and CSR read data (environment)
//                slave  : the sequencer itself
//  Ports       : req_valid/req_is_mret/req_pc/req_cause/req_ready  request
//                csr_rs/csra                                      CSR read
//                csr_rd/csr_wd/csrwEnable                         CSR write
//                redirect_valid/redirect_pc                       fetch load
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface trap_sequencer_if;
    logic        req_valid;
    logic        req_is_mret;
    logic [31:0] req_pc;
    logic [31:0] req_cause;
    logic        req_ready;
    logic [1:0]  csr_rs;
    logic [31:0] csra;
    logic [1:0]  csr_rd;
    logic [31:0] csr_wd;
    logic        csrwEnable;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    modport master (
        output req_valid, req_is_mret, req_pc, req_cause, csra,
        input  req_ready, csr_rs, csr_rd, csr_wd, csrwEnable,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  req_valid, req_is_mret, req_pc, req_cause, csra,
        output req_ready, csr_rs, csr_rd, csr_wd, csrwEnable,
               redirect_valid, redirect_pc
    );
endinterface

`default_nettype wire

// File: rtl/trap_sequencer.sv
// ============================================================================
//  Module      : trap_sequencer
//  Description : Multi-cycle machine-mode trap entry (ecall) and trap return
//                (mret) sequencer. Trap entry writes mepc, mcause, mstatus and
//                redirects fetch to mtvec; return rewrites mstatus and
//                redirects fetch to mepc. One CSR write per cycle.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous reset, active low
//                bus  - trap_sequencer_if.slave (request, CSR, redirect)
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module trap_sequencer #(
    parameter logic [1:0]  MPP_M     = 2'b11,
    parameter logic [31:0] TVEC_MASK = 32'hFFFF_FFFC
) (
    input  wire logic         clk,
    input  wire logic         rst,
    trap_sequencer_if.slave   bus
);

    localparam logic [1:0] c_CSR_MCAUSE  = 2'd0;
    localparam logic [1:0] c_CSR_MEPC    = 2'd1;
    localparam logic [1:0] c_CSR_MSTATUS = 2'd2;
    localparam logic [1:0] c_CSR_MTVEC   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_E_EPC    = 3'd1,
        S_E_CAUSE  = 3'd2,
        S_E_STATUS = 3'd3,
        S_E_VEC    = 3'd4,
        S_R_STATUS = 3'd5,
        S_R_PC     = 3'd6
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_cause;
    logic        r_req_ready;
    logic [1:0]  r_csr_rs;
    logic [1:0]  r_csr_rd;
    logic        r_we;
    logic        r_rv;

    logic        w_accept;
    logic [31:0] w_status_entry;
    logic [31:0] w_status_return;
    logic [31:0] w_csr_wd;
    logic [31:0] w_redirect_pc;

    assign w_accept = bus.req_valid && r_req_ready;

    // ------------------------------------------------------------------------
    // State register. The control outputs are registered one cycle ahead: the
    // value loaded on a transition is the value the destination state drives,
    // so csr_rs is already stable when csra is consumed in that state.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_pc        <= 32'd0;
            r_cause     <= 32'd0;
            r_req_ready <= 1'b1;
            r_csr_rs    <= 2'd0;
            r_csr_rd    <= 2'd0;
            r_we        <= 1'b0;
            r_rv        <= 1'b0;
        end else begin
            r_req_ready <= 1'b0;
            r_csr_rs    <= 2'd0;
            r_csr_rd    <= 2'd0;
            r_we        <= 1'b0;
            r_rv        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_pc    <= bus.req_pc;
                        r_cause <= bus.req_cause;
                        if (!bus.req_is_mret) begin
                            r_state  <= S_E_EPC;
                            r_csr_rd <= c_CSR_MEPC;
                            r_we     <= 1'b1;
                        end else begin
                            r_state  <= S_R_STATUS;
                            r_csr_rs <= c_CSR_MSTATUS;
                            r_csr_rd <= c_CSR_MSTATUS;
                            r_we     <= 1'b1;
                        end
                    end else begin
                        r_req_ready <= 1'b1;
                    end
                end
                S_E_EPC: begin
                    r_state  <= S_E_CAUSE;
                    r_csr_rd <= c_CSR_MCAUSE;
                    r_we     <= 1'b1;
                end
                S_E_CAUSE: begin
                    r_state  <= S_E_STATUS;
                    r_csr_rs <= c_CSR_MSTATUS;
                    r_csr_rd <= c_CSR_MSTATUS;
                    r_we     <= 1'b1;
                end
                S_E_STATUS: begin
                    r_state  <= S_E_VEC;
                    r_csr_rs <= c_CSR_MTVEC;
                    r_rv     <= 1'b1;
                end
                S_R_STATUS: begin
                    r_state  <= S_R_PC;
                    r_csr_rs <= c_CSR_MEPC;
                    r_rv     <= 1'b1;
                end
                // Both redirect states return to IDLE; ready only rises here,
                // so a request seen during the redirect pulse is not taken.
                S_E_VEC, S_R_PC: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // mstatus rewrites. Data comes from csra in the same cycle, so these paths
    // are combinational from the CSR read port.
    // ------------------------------------------------------------------------
    always_comb begin
        w_status_entry        = bus.csra;
        w_status_entry[7]     = bus.csra[3];   // MPIE <- MIE
        w_status_entry[3]     = 1'b0;          // MIE cleared
        w_status_entry[12:11] = MPP_M;

        w_status_return        = bus.csra;
        w_status_return[3]     = bus.csra[7];  // MIE <- MPIE
        w_status_return[7]     = 1'b1;
        w_status_return[12:11] = 2'b00;
    end

    always_comb begin
        w_csr_wd      = 32'd0;
        w_redirect_pc = 32'd0;
        case (r_state)
            S_E_EPC:    w_csr_wd      = r_pc;
            S_E_CAUSE:  w_csr_wd      = r_cause;
            S_E_STATUS: w_csr_wd      = w_status_entry;
            S_R_STATUS: w_csr_wd      = w_status_return;
            S_E_VEC:    w_redirect_pc = bus.csra & TVEC_MASK;
            S_R_PC:     w_redirect_pc = bus.csra;
            default: begin
                w_csr_wd      = 32'd0;
                w_redirect_pc = 32'd0;
            end
        endcase
    end

    assign bus.req_ready      = r_req_ready;
    assign bus.csr_rs         = r_csr_rs;
    assign bus.csr_rd         = r_csr_rd;
    assign bus.csrwEnable     = r_we;
    assign bus.redirect_valid = r_rv;
    assign bus.csr_wd         = w_csr_wd;
    assign bus.redirect_pc    = w_redirect_pc;

endmodule

`default_nettype wire
